// File: rtl/booth_mul_sched.sv
// Round-robin scheduler sharing one fixed-latency sequential Booth multiplier among NREQ requesters.
// Optional MUL_SCHED_ABORT_EN: a granted requester dropping req during RUN aborts its operation.
module booth_mul_sched #(
  parameter int N       = 5,
  parameter int NREQ    = 4,
  parameter int MUL_LAT = N + 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*N-1:0] a_in,
  input  logic [NREQ*N-1:0] b_in,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic [2*N-1:0]    product_out,
  output logic              busy,
  output logic [N-1:0]      mul_a,
  output logic [N-1:0]      mul_b,
  output logic              mul_clr,
  input  logic [2*N-1:0]    mul_product
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(MUL_LAT + 1);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] ptr, id, pick, idx, nxt_id;
  logic          pick_vld;
  int            idx_i;
  logic [CW-1:0] cnt;
  logic          run_end, abort;

  // Scan from the farthest position back to the pointer so the nearest set bit wins.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    idx      = '0;
    idx_i    = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx_i = (int'(ptr) + k) % NREQ;
      idx   = IW'(idx_i);
      if (req[idx]) begin
        pick     = idx;
        pick_vld = 1'b1;
      end
    end
  end

  assign run_end = (cnt == CW'(MUL_LAT - 1));
  assign nxt_id  = (id == IW'(NREQ - 1)) ? '0 : id + 1'b1;

`ifdef MUL_SCHED_ABORT_EN
  assign abort = ~req[id];
`else
  assign abort = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_vld) state_nxt = LOAD;
      LOAD:    state_nxt = RUN;
      RUN: begin
        if (abort)        state_nxt = IDLE;
        else if (run_end) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy    = (state != IDLE);
    mul_clr = (state != RUN);
    done    = (state == DONE) ? gnt : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt         <= '0;
      id          <= '0;
      ptr         <= '0;
      cnt         <= '0;
      mul_a       <= '0;
      mul_b       <= '0;
      product_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_vld) begin
            id    <= pick;
            gnt   <= NREQ'(1) << pick;
            mul_a <= a_in[pick*N +: N];
            mul_b <= b_in[pick*N +: N];
          end
        end
        LOAD: cnt <= '0;
        RUN: begin
          cnt <= cnt + 1'b1;
          if (abort) begin
            gnt <= '0;
            ptr <= nxt_id;
          end else if (run_end) begin
            product_out <= mul_product;
          end
        end
        DONE: begin
          gnt <= '0;
          ptr <= nxt_id;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/booth_mul_sched.md
# booth_mul_sched

Round-robin scheduler that shares one sequential Booth multiplier between `NREQ` requesters. It arbitrates requests, latches the winner's operands and drives the multiplier's operand and clear inputs. It times the fixed-latency multiplication with a counter, then returns the signed product to the granted requester with a one-cycle `done` pulse. It sits between client blocks and the multiplier instance, which has no done/valid output of its own.

## Interface
- `N`, 5: operand width in bits (signed two's complement).
- `NREQ`, 4: number of requesters (2..8).
- `MUL_LAT`, `N+2`: number of cycles the multiplier needs after its clear is released before `mul_product` is valid.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: reset, asynchronous, active-low.
- `req`  in  NREQ: request per requester; held high until its `done` pulse.
- `a_in`  in  NREQ*N: operand A of requester i at bits [i*N +: N].
- `b_in`  in  NREQ*N: operand B of requester i at bits [i*N +: N].
- `gnt`  out  NREQ: one-hot grant, or zero when no requester is granted.
- `done`  out  NREQ: one-cycle pulse on the granted requester's bit when `product_out` is valid.
- `product_out`  out  2N: last completed product; holds until the next completion.
- `busy`  out  1: high in any state except IDLE.
- `mul_a`, `mul_b`  out  N: operands to the multiplier.
- `mul_clr`  out  1: active-high hold/clear to the multiplier; a falling edge starts a multiplication.
- `mul_product`  in  2N: multiplier result.

## Operation
- Reset values: FSM=IDLE, `gnt`=0, `done`=0, `product_out`=0, `busy`=0, `mul_a`=`mul_b`=0, `mul_clr`=1, RR pointer=0, counter=0.
- FSM states: IDLE, LOAD, RUN, DONE.
- IDLE: if `req`≠0, select the first set bit at or after the pointer, wrapping from NREQ-1 to 0. Latch that requester's `a_in`/`b_in` into `mul_a`/`mul_b`, set the `gnt` bit, go to LOAD. If `req`=0, stay in IDLE.
- LOAD: `mul_clr`=1 with stable operands. Go to RUN and clear the counter.
- RUN: `mul_clr`=0. Counter increments each cycle. When the counter equals MUL_LAT-1, capture `mul_product` into `product_out` and go to DONE.
- DONE: `done[id]`=1 and `mul_clr`=1. Set the pointer to (id+1) mod NREQ and go to IDLE, clearing `gnt`.
- `a_in`/`b_in` are sampled only in the IDLE grant cycle. Later changes have no effect on the current operation.
- Requests that arrive while `busy` is high wait. They are evaluated in the next IDLE cycle.
- If a requester's `req` is still high in the IDLE cycle after its `done`, it counts as a new request. It has lowest priority because the pointer has moved past it.
- Product width is 2N and signed. `product_out` equals `mul_product` exactly, with no truncation or extension.
- Reset asserted mid-operation: all outputs return to reset values immediately and no `done` is issued.

## Timing
- Cycle 0 is the IDLE cycle in which `req` is first seen. LOAD is cycle 1, RUN is cycles 2..MUL_LAT+1, DONE is cycle MUL_LAT+2.
- Request-to-`done` latency is MUL_LAT+2 cycles (9 with the defaults).
- `gnt` is high in cycles 1..MUL_LAT+2.
- The minimum gap between back-to-back operations is one IDLE cycle. Throughput is one product per MUL_LAT+3 cycles.
- `product_out` updates on the same edge that enters DONE.

## Configuration
- Macro: `MUL_SCHED_ABORT_EN`.
- Defined: if the granted requester's `req` is low during RUN, go to IDLE on the next edge. `mul_clr` returns to 1, `gnt` clears, no `done` is issued, `product_out` is unchanged, and the pointer advances past the aborted requester.
- Not defined: dropping `req` during LOAD or RUN is ignored. The operation completes and `done` pulses normally.

## Test plan
All cases use the defaults (N=5, NREQ=4, MUL_LAT=7) with a behavioural multiplier model whose output is signed a*b valid MUL_LAT cycles after `mul_clr` falls.

- Single request: `req`=0001, a0=01110 (14), b0=11011 (-5). Required: `gnt`=0001 in cycles 1-9, `done`=0001 in cycle 9, `product_out`=1110111010 (-70).
- Simultaneous requests: `req`=0101 with a0=3, b0=4 and a2=-16, b2=-16. Required: requester 0 completes first with 12, then requester 2 with 256 (0100000000). The second `done` comes 10 cycles after the first.
- Fairness: all four `req` held high continuously. Required: grant order 0,1,2,3,0 with no requester granted twice before the others.
- Reset mid-operation: `rst` driven low during RUN. Required: `gnt`=0, `busy`=0, `mul_clr`=1, `product_out`=0 immediately, and no `done`. After release, a fresh request completes normally.
- Request drop: requester 1 drops `req` in the third RUN cycle. Required without the macro: `done`=0010 still pulses at cycle 9. Required with `MUL_SCHED_ABORT_EN`: no `done`, IDLE on the next edge, and `product_out` is unchanged.
- Extreme operands: a=10000 (-16), b=10000 (-16). Required: `product_out`=0100000000 (+256), with no overflow or sign error.
